hud_rom_arbiter: RTL and testbench

HUD_ROM_ARBITER -- requirements
Module: hud_rom_arbiter

---
 rtl/hud_rom_arbiter.sv | 88 ++++++++
 tb/tb_hud_rom_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hud_rom_arbiter.sv
// Two-requester glyph ROM arbiter for the HUD overlay. The label reader normally has priority;
// the digit renderer wins once it has been starved for STARVE_LIMIT consecutive cycles.
module hud_rom_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clock_25,
  input  logic              reset,
  input  logic              hud_enable,
  input  logic              label_req,
  input  logic [ADDR_W-1:0] label_addr,
  input  logic              digit_req,
  input  logic [ADDR_W-1:0] digit_addr,
  output logic              label_gnt,
  output logic              digit_gnt,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              label_valid,
  output logic              label_data,
  output logic              digit_valid,
  output logic              digit_data
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic {OwnLabel, OwnDigit} owner_e;

  logic [CntW-1:0] starve_q, starve_d;
  logic            grant_any;
  owner_e          s1_owner_q, s2_owner_q;
  logic            s2_valid_q;

  // Grants are gated by reset so they drop the instant reset asserts.
  always_comb begin
    label_gnt = 1'b0;
    digit_gnt = 1'b0;
    if (!reset && hud_enable) begin
      if (label_req && (starve_q < StarveMax)) begin
        label_gnt = 1'b1;
      end else if (digit_req) begin
        digit_gnt = 1'b1;
      end
    end
    grant_any = label_gnt | digit_gnt;
  end

  always_comb begin
    starve_d = starve_q;
    if (hud_enable) begin
      if (!digit_req || digit_gnt) begin
        starve_d = '0;
      end else if (starve_q < StarveMax) begin
        starve_d = starve_q + CntW'(1);
      end
    end
  end

  // Stage 1 is the ROM strobe itself (rom_en + owner); stage 2 lines up with rom_data.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      starve_q   <= '0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      s1_owner_q <= OwnLabel;
      s2_valid_q <= 1'b0;
      s2_owner_q <= OwnLabel;
    end else begin
      starve_q   <= starve_d;
      rom_en     <= grant_any;
      if (grant_any) begin
        rom_addr   <= digit_gnt ? digit_addr : label_addr;
        s1_owner_q <= digit_gnt ? OwnDigit : OwnLabel;
      end
      s2_valid_q <= rom_en;
      s2_owner_q <= s1_owner_q;
    end
  end

  always_comb begin
    label_valid = s2_valid_q && (s2_owner_q == OwnLabel);
    digit_valid = s2_valid_q && (s2_owner_q == OwnDigit);
    label_data  = label_valid & rom_data;
    digit_data  = digit_valid & rom_data;
  end

endmodule

// File: tb/tb_hud_rom_arbiter.sv
// Self-checking bench for hud_rom_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level model.
module tb_hud_rom_arbiter;

  localparam int unsigned ADDR_W       = 12;
  localparam int unsigned STARVE_LIMIT = 3;

  logic              clock_25   = 1'b0;
  logic              reset      = 1'b1;
  logic              hud_enable = 1'b0;
  logic              label_req  = 1'b0;
  logic [ADDR_W-1:0] label_addr = '0;
  logic              digit_req  = 1'b0;
  logic [ADDR_W-1:0] digit_addr = '0;
  logic              rom_data   = 1'b0;
  logic              label_gnt, digit_gnt, rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              label_valid, label_data, digit_valid, digit_data;

  always #5 clock_25 = ~clock_25;

  hud_rom_arbiter #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .hud_enable (hud_enable),
    .label_req  (label_req),
    .label_addr (label_addr),
    .digit_req  (digit_req),
    .digit_addr (digit_addr),
    .label_gnt  (label_gnt),
    .digit_gnt  (digit_gnt),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .label_valid(label_valid),
    .label_data (label_data),
    .digit_valid(digit_valid),
    .digit_data (digit_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: outstanding reads as {due cycle, owner, address}.
  typedef struct {
    int                due;
    bit                is_digit;
    logic [ADDR_W-1:0] addr;
  } resp_t;
  resp_t pend[$];

  int                m_starve   = 0;
  bit                m_rom_en   = 1'b0;
  logic [ADDR_W-1:0] m_rom_addr = '0;
  bit                e_lg = 1'b0, e_dg = 1'b0;

  logic              a_lg, a_dg, a_en, a_lv, a_dv;
  logic [ADDR_W-1:0] a_addr;

  function automatic logic rom_bit(input logic [ADDR_W-1:0] a);
    return ~^a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Entered just after a rising edge; drives one cycle, checks mid-cycle, updates the model.
  task automatic run_cycle(input bit rst, input bit en, input bit lr,
                           input logic [ADDR_W-1:0] la, input bit dr,
                           input logic [ADDR_W-1:0] da);
    bit rv_l, rv_d, rdat;
    reset = rst; hud_enable = en; label_req = lr; label_addr = la;
    digit_req = dr; digit_addr = da;
    if (rst) begin
      pend.delete();
      m_starve = 0; m_rom_en = 1'b0; m_rom_addr = '0;
    end
    rv_l = 1'b0; rv_d = 1'b0; rdat = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rdat = rom_bit(pend[0].addr);
      rv_l = !pend[0].is_digit;
      rv_d = pend[0].is_digit;
      rom_data = rdat;
    end else begin
      rom_data = 1'($urandom);
    end
    e_lg = !rst && en && lr && (m_starve < int'(STARVE_LIMIT));
    e_dg = !rst && en && !e_lg && dr;

    @(negedge clock_25);
    a_lg = label_gnt; a_dg = digit_gnt; a_en = rom_en; a_addr = rom_addr;
    a_lv = label_valid; a_dv = digit_valid;
    chk("label_gnt", label_gnt, e_lg);
    chk("digit_gnt", digit_gnt, e_dg);
    chk("rom_en", rom_en, m_rom_en);
    chk("rom_addr", rom_addr, m_rom_addr);
    chk("label_valid", label_valid, rv_l);
    chk("label_data", label_data, rv_l & rdat);
    chk("digit_valid", digit_valid, rv_d);
    chk("digit_data", digit_data, rv_d & rdat);

    @(posedge clock_25);
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (!rst) begin
      m_rom_en = e_lg | e_dg;
      if (e_lg | e_dg) begin
        m_rom_addr = e_dg ? da : la;
        pend.push_back('{cyc + 2, e_dg, m_rom_addr});
      end
      if (en) begin
        if (!dr || e_dg) m_starve = 0;
        else if (m_starve < int'(STARVE_LIMIT)) m_starve = m_starve + 1;
      end
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    bit                rst, en, lr;
    logic [ADDR_W-1:0] la;
    bit                dr;
    logic [ADDR_W-1:0] da;
    bit                lg, dg, ren, lv, dv;
  } vec_t;
  vec_t vecs[$];

  initial begin
    bit                lr_s, dr_s, en_s, rst_s;
    logic [ADDR_W-1:0] la_s, da_s;

    // rst en lr la dr da | lg dg ren lv dv
    vecs.push_back('{1, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 12'h0A5, 0, 12'h000, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 12'h0A5, 0, 12'h000, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 1, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 1, 12'h101, 1, 12'h203, 0, 1, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 0});

    repeat (2) @(posedge clock_25);
    #1;

    foreach (vecs[i]) begin
      run_cycle(vecs[i].rst, vecs[i].en, vecs[i].lr, vecs[i].la, vecs[i].dr, vecs[i].da);
      chk("vec_label_gnt", a_lg, vecs[i].lg);
      chk("vec_digit_gnt", a_dg, vecs[i].dg);
      chk("vec_rom_en", a_en, vecs[i].ren);
      chk("vec_label_valid", a_lv, vecs[i].lv);
      chk("vec_digit_valid", a_dv, vecs[i].dv);
    end

    // Back-to-back grants with alternating addresses and owners.
    run_cycle(0, 1, 1, 12'h010, 0, 12'h000);
    run_cycle(0, 1, 0, 12'h000, 1, 12'h020);
    chk("b2b_addr0", {a_en, a_addr}, {1'b1, 12'h010});
    run_cycle(0, 1, 0, 12'h000, 0, 12'h000);
    chk("b2b_addr1", {a_en, a_addr}, {1'b1, 12'h020});
    chk("b2b_resp0", {a_lv, a_dv}, 2'b10);
    run_cycle(0, 1, 0, 12'h000, 0, 12'h000);
    chk("b2b_resp1", {a_lv, a_dv}, 2'b01);

    // hud_enable drops the cycle after a grant; the granted read still returns.
    run_cycle(0, 1, 1, 12'h3C3, 0, 12'h000);
    run_cycle(0, 0, 1, 12'h0F0, 1, 12'h00F);
    chk("dis_no_gnt", {a_lg, a_dg}, 2'b00);
    chk("dis_rom_en_pending", a_en, 1'b1);
    run_cycle(0, 0, 1, 12'h0F0, 1, 12'h00F);
    chk("dis_rom_en_off", a_en, 1'b0);
    chk("dis_resp", a_lv, 1'b1);
    run_cycle(0, 0, 1, 12'h0F0, 1, 12'h00F);
    chk("dis_quiet", {a_lg, a_dg, a_en, a_lv, a_dv}, 5'b0);
    run_cycle(0, 1, 0, 12'h000, 0, 12'h000);

    // Reset pulsed the cycle after a grant discards the in-flight read.
    run_cycle(0, 1, 0, 12'h000, 1, 12'h555);
    run_cycle(1, 1, 0, 12'h000, 1, 12'h555);
    chk("rst_quiet", {a_lg, a_dg, a_en, a_lv, a_dv, a_addr}, 17'b0);
    run_cycle(0, 1, 0, 12'h000, 0, 12'h000);
    chk("rst_no_resp0", {a_lv, a_dv}, 2'b00);
    run_cycle(0, 1, 0, 12'h000, 0, 12'h000);
    chk("rst_no_resp1", {a_lv, a_dv}, 2'b00);

    // Randomized traffic: requests held until granted, occasionally dropped.
    lr_s = 1'b0; dr_s = 1'b0; en_s = 1'b1; la_s = '0; da_s = '0;
    for (int i = 0; i < 3000; i++) begin
      if (lr_s && !e_lg) lr_s = ($urandom_range(0, 9) != 0);
      else begin
        lr_s = 1'($urandom_range(0, 1));
        la_s = ADDR_W'($urandom);
      end
      if (dr_s && !e_dg) dr_s = ($urandom_range(0, 9) != 0);
      else begin
        dr_s = ($urandom_range(0, 3) != 0);
        da_s = ADDR_W'($urandom);
      end
      if ($urandom_range(0, 19) == 0) en_s = !en_s;
      rst_s = ($urandom_range(0, 249) == 0);
      run_cycle(rst_s, en_s, lr_s, la_s, dr_s, da_s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
